cell_fifo_packer: RTL and testbench



---
 rtl/cell_fifo_packer_if.sv | 13 +
 rtl/cell_fifo_packer.sv | 114 +++++++++++
 tb/tb_cell_fifo_packer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cell_fifo_packer_if.sv
// Packet stream handshake feeding the cell FIFO packer: valid/ready with sop/eop framing.
interface cell_fifo_packer_if #(
  parameter int DWIDTH = 8
);
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [DWIDTH-1:0] data;

  modport master (output valid, sop, eop, data, input ready);
  modport slave  (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/cell_fifo_packer.sv
// Segments a sop/eop framed word stream into fixed 2^CWIDTH-word FIFO cells,
// padding the last partial cell so the FIFO only ever receives complete cells.
module cell_fifo_packer #(
  parameter int                  DWIDTH    = 8,
  parameter int                  CWIDTH    = 2,
  parameter logic [DWIDTH-1:0]   PAD_DATA  = '0,
  parameter int                  CNT_WIDTH = 16,
  parameter int                  U_DLY     = 1
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst,
  cell_fifo_packer_if.slave    s,
  output logic                 o_wen,
  output logic                 o_weoc,
  output logic [CWIDTH-1:0]    o_waddr,
  output logic [DWIDTH-1:0]    o_wdata,
  input  logic                 i_full,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt,
  output logic [CNT_WIDTH-1:0] o_cell_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAD = 2'd2} state_t;

  localparam logic [CWIDTH-1:0] LAST = {CWIDTH{1'b1}};

  state_t            state;
  logic [CWIDTH-1:0] r_widx;
  logic              acc;
  logic              at_last;

  assign at_last = (r_widx == LAST);
  assign acc     = s.valid & s.ready;

  // i_full is only consulted when a new cell would start (index 0); once a
  // cell is admitted it always runs to completion, including its pad words.
  always_comb begin
    s.ready = 1'b0;
    o_wen   = 1'b0;
    unique case (state)
      IDLE: begin
        s.ready = !i_full;
        o_wen   = acc & s.sop;
      end
      DATA: begin
        s.ready = !((r_widx == '0) & i_full);
        o_wen   = acc;
      end
      PAD: begin
        s.ready = 1'b0;
        o_wen   = 1'b1;
      end
      default: begin
        s.ready = 1'b0;
        o_wen   = 1'b0;
      end
    endcase
  end

  assign o_weoc  = o_wen & at_last;
  assign o_waddr = r_widx;
  assign o_wdata = (state == PAD) ? PAD_DATA : s.data;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      r_widx     <= '0;
      o_err      <= 1'b0;
      o_pkt_cnt  <= '0;
      o_cell_cnt <= '0;
    end else begin
      o_err <= 1'b0;
      if (o_weoc) o_cell_cnt <= o_cell_cnt + CNT_WIDTH'(1);
      unique case (state)
        IDLE: begin
          if (acc) begin
            if (s.sop) begin
              r_widx <= r_widx + CWIDTH'(1);
              if (s.eop) begin
                o_pkt_cnt <= o_pkt_cnt + CNT_WIDTH'(1);
                state     <= at_last ? IDLE : PAD;
              end else begin
                state <= DATA;
              end
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (acc) begin
            r_widx <= r_widx + CWIDTH'(1);
            if (s.sop) o_err <= 1'b1;
            if (s.eop) begin
              o_pkt_cnt <= o_pkt_cnt + CNT_WIDTH'(1);
              state     <= at_last ? IDLE : PAD;
            end
          end
        end
        PAD: begin
          r_widx <= r_widx + CWIDTH'(1);
          if (at_last) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          r_widx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_fifo_packer.sv
// Directed bench for cell_fifo_packer: CWIDTH=2 (4-word cells), pad word 8'hEE.
module tb_cell_fifo_packer;

  localparam logic [7:0] PADW = 8'hEE;

  logic        clk;
  logic        rst;
  logic        full;
  logic        wen, weoc, busy, err;
  logic [1:0]  waddr;
  logic [7:0]  wdata;
  logic [15:0] pkt_cnt, cell_cnt;
  int          total;
  int          bad;

  cell_fifo_packer_if #(.DWIDTH(8)) s_if ();

  cell_fifo_packer #(
    .DWIDTH(8), .CWIDTH(2), .PAD_DATA(PADW), .CNT_WIDTH(16), .U_DLY(1)
  ) dut (
    .i_clk_sys  (clk),
    .i_rst      (rst),
    .s          (s_if.slave),
    .o_wen      (wen),
    .o_weoc     (weoc),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .i_full     (full),
    .o_busy     (busy),
    .o_err      (err),
    .o_pkt_cnt  (pkt_cnt),
    .o_cell_cnt (cell_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check the combinational write outputs mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic v, input logic so, input logic eo,
                     input logic f, input logic [7:0] d, input logic xr, input logic xw,
                     input logic xe, input logic [1:0] xa, input logic [7:0] xd);
    s_if.valid = v; s_if.sop = so; s_if.eop = eo; s_if.data = d; full = f;
    #1;
    chk({tag, ".rdy"},  32'(s_if.ready), 32'(xr));
    chk({tag, ".wen"},  32'(wen),        32'(xw));
    chk({tag, ".weoc"}, 32'(weoc),       32'(xe));
    if (xw) begin
      chk({tag, ".addr"}, 32'(waddr), 32'(xa));
      chk({tag, ".data"}, 32'(wdata), 32'(xd));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string tag, input logic xbusy, input int xp, input int xc);
    s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0; full = 1'b0;
    #1;
    chk({tag, ".busy"}, 32'(busy),     32'(xbusy));
    chk({tag, ".pkt"},  32'(pkt_cnt),  32'(xp));
    chk({tag, ".cell"}, 32'(cell_cnt), 32'(xc));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; full = 1'b0;
    s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0; s_if.data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err",  32'(err), 0);
    chk("rst.wen",  32'(wen), 0);
    chk("rst.pkt",  32'(pkt_cnt), 0);
    chk("rst.cell", 32'(cell_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-word packet: two full cells, no padding
    for (int i = 0; i < 8; i++)
      cyc("p8", 1, i == 0, i == 7, 0, 8'h10 + 8'(i), 1, 1, (i % 4) == 3, 2'(i % 4), 8'h10 + 8'(i));
    idle_chk("p8.end", 0, 1, 2);

    // 5-word packet: second cell padded at addr 1..3
    for (int i = 0; i < 5; i++)
      cyc("p5", 1, i == 0, i == 4, 0, 8'h20 + 8'(i), 1, 1, (i % 4) == 3, 2'(i % 4), 8'h20 + 8'(i));
    for (int i = 1; i < 4; i++)
      cyc("p5.pad", 0, 0, 0, 0, 8'h00, 0, 1, i == 3, 2'(i), PADW);
    idle_chk("p5.end", 0, 2, 4);

    // single-word packet
    cyc("p1", 1, 1, 1, 0, 8'h40, 1, 1, 0, 2'd0, 8'h40);
    chk("p1.busy", 32'(busy), 1);
    for (int i = 1; i < 4; i++)
      cyc("p1.pad", 0, 0, 0, 0, 8'h00, 0, 1, i == 3, 2'(i), PADW);
    idle_chk("p1.end", 0, 3, 5);

    // full mid-cell is ignored; full at the cell boundary stalls
    cyc("f.w0", 1, 1, 0, 0, 8'h50, 1, 1, 0, 2'd0, 8'h50);
    cyc("f.w1", 1, 0, 0, 1, 8'h51, 1, 1, 0, 2'd1, 8'h51);
    cyc("f.w2", 1, 0, 0, 0, 8'h52, 1, 1, 0, 2'd2, 8'h52);
    cyc("f.w3", 1, 0, 0, 0, 8'h53, 1, 1, 1, 2'd3, 8'h53);
    cyc("f.st0", 1, 0, 0, 1, 8'h54, 0, 0, 0, 2'd0, 8'h00);
    cyc("f.st1", 1, 0, 0, 1, 8'h54, 0, 0, 0, 2'd0, 8'h00);
    cyc("f.w4", 1, 0, 0, 0, 8'h54, 1, 1, 0, 2'd0, 8'h54);
    cyc("f.w5", 1, 0, 1, 0, 8'h55, 1, 1, 0, 2'd1, 8'h55);
    cyc("f.pad2", 0, 0, 0, 1, 8'h00, 0, 1, 0, 2'd2, PADW);
    cyc("f.pad3", 0, 0, 0, 1, 8'h00, 0, 1, 1, 2'd3, PADW);
    idle_chk("f.end", 0, 4, 7);

    // framing errors: stray word in IDLE, sop inside a packet
    cyc("e.drop", 1, 0, 0, 0, 8'h60, 1, 0, 0, 2'd0, 8'h00);
    chk("e.drop.err1", 32'(err), 1);
    cyc("e.idle", 0, 0, 0, 0, 8'h00, 1, 0, 0, 2'd0, 8'h00);
    chk("e.drop.err0", 32'(err), 0);
    cyc("e.w0", 1, 1, 0, 0, 8'h70, 1, 1, 0, 2'd0, 8'h70);
    cyc("e.w1", 1, 1, 0, 0, 8'h71, 1, 1, 0, 2'd1, 8'h71);
    chk("e.sop.err1", 32'(err), 1);
    cyc("e.w2", 1, 0, 0, 0, 8'h72, 1, 1, 0, 2'd2, 8'h72);
    chk("e.sop.err0", 32'(err), 0);
    cyc("e.w3", 1, 0, 1, 0, 8'h73, 1, 1, 1, 2'd3, 8'h73);
    idle_chk("e.end", 0, 5, 8);

    // asynchronous reset in the middle of a cell
    cyc("r.w0", 1, 1, 0, 0, 8'h80, 1, 1, 0, 2'd0, 8'h80);
    cyc("r.w1", 1, 0, 0, 0, 8'h81, 1, 1, 0, 2'd1, 8'h81);
    s_if.valid = 1'b1; s_if.sop = 1'b0; s_if.eop = 1'b0; s_if.data = 8'h82;
    #2 rst = 1'b1;
    #1;
    chk("r.busy", 32'(busy), 0);
    chk("r.wen",  32'(wen), 0);
    chk("r.pkt",  32'(pkt_cnt), 0);
    chk("r.cell", 32'(cell_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("r.new", 1, 1, 1, 0, 8'h90, 1, 1, 0, 2'd0, 8'h90);
    for (int i = 1; i < 4; i++)
      cyc("r.pad", 0, 0, 0, 0, 8'h00, 0, 1, i == 3, 2'(i), PADW);
    idle_chk("r.end", 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule
